// File: rtl/otter_ex_operand_stage.sv
// ID/EX operand stage feeding the OTTER ALU: register-operand resolution, srcA/srcB muxing, load-use stall.
// Build option: define OTTER_FWD_EN to enable MEM/WB forwarding; otherwise decode stalls on any in-flight match.
module otter_ex_operand_stage #(
    parameter int XLEN      = 32,
    parameter int LU_BUBBLE = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            flush,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_immed,
    input  logic [XLEN-1:0] id_pc,
    input  logic [1:0]      id_srcA_sel,
    input  logic [1:0]      id_srcB_sel,
    input  logic [3:0]      id_alu_fun,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,

    input  logic [4:0]      fwd1_rd,
    input  logic            fwd1_we,
    input  logic [XLEN-1:0] fwd1_data,
    input  logic [4:0]      fwd0_rd,
    input  logic            fwd0_we,
    input  logic [XLEN-1:0] fwd0_data,

    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_srcA,
    output logic [XLEN-1:0] ex_srcB,
    output logic [3:0]      ex_alu_fun,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read
);

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_IMM  = 2'd1,
        SRCA_PC   = 2'd2,
        SRCA_ZERO = 2'd3
    } srca_sel_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_ZERO = 2'd3
    } srcb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [XLEN-1:0] rs2_data;
        logic [3:0]      alu_fun;
        logic [4:0]      rd_addr;
        logic            reg_write;
        logic            mem_read;
    } ex_entry_t;

    ex_entry_t       entry_q, entry_d;
    logic            valid_q;
    logic [1:0]      bubble_q, bubble_d;

    logic            rs1_used, rs2_used;
    logic            lu_hazard, raw_hazard, hazard;
    logic            capture, depart;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // A writer matches a source only when it writes and the source is not x0.
    function automatic logic src_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd == rs) && (rs != 5'd0);
    endfunction

    assign rs1_used = (srca_sel_e'(id_srcA_sel) == SRCA_RS1);
    assign rs2_used = (srcb_sel_e'(id_srcB_sel) == SRCB_RS2);

    assign lu_hazard = valid_q && entry_q.mem_read && (entry_q.rd_addr != 5'd0) &&
                       ((rs1_used && (entry_q.rd_addr == id_rs1_addr)) ||
                        (rs2_used && (entry_q.rd_addr == id_rs2_addr)));

`ifdef OTTER_FWD_EN
    assign raw_hazard = 1'b0;

    always_comb begin
        rs1_val = id_rs1_data;
        if (id_rs1_addr == 5'd0)
            rs1_val = '0;
        else if (src_match(fwd1_we, fwd1_rd, id_rs1_addr))
            rs1_val = fwd1_data;
        else if (src_match(fwd0_we, fwd0_rd, id_rs1_addr))
            rs1_val = fwd0_data;
    end

    always_comb begin
        rs2_val = id_rs2_data;
        if (id_rs2_addr == 5'd0)
            rs2_val = '0;
        else if (src_match(fwd1_we, fwd1_rd, id_rs2_addr))
            rs2_val = fwd1_data;
        else if (src_match(fwd0_we, fwd0_rd, id_rs2_addr))
            rs2_val = fwd0_data;
    end
`else
    // Without forwarding the in-flight data is never selected; decode waits for writeback instead.
    logic unused_fwd_data;
    assign unused_fwd_data = ^{fwd1_data, fwd0_data};

    assign raw_hazard =
        (rs1_used && (src_match(valid_q && entry_q.reg_write, entry_q.rd_addr, id_rs1_addr) ||
                      src_match(fwd1_we, fwd1_rd, id_rs1_addr) ||
                      src_match(fwd0_we, fwd0_rd, id_rs1_addr))) ||
        (rs2_used && (src_match(valid_q && entry_q.reg_write, entry_q.rd_addr, id_rs2_addr) ||
                      src_match(fwd1_we, fwd1_rd, id_rs2_addr) ||
                      src_match(fwd0_we, fwd0_rd, id_rs2_addr)));

    assign rs1_val = (id_rs1_addr == 5'd0) ? '0 : id_rs1_data;
    assign rs2_val = (id_rs2_addr == 5'd0) ? '0 : id_rs2_data;
`endif

    assign hazard   = lu_hazard || raw_hazard;
    assign id_ready = (!valid_q || ex_ready) && !hazard && (bubble_q == 2'd0);
    assign capture  = id_valid && id_ready && !flush;
    assign depart   = valid_q && ex_ready;

    // NOTE: every variable written in a combinational block gets a default first, so no latch can form.
    always_comb begin
        entry_d           = '0;
        entry_d.rs2_data  = rs2_val;
        entry_d.alu_fun   = id_alu_fun;
        entry_d.rd_addr   = id_rd_addr;
        entry_d.reg_write = id_reg_write;
        entry_d.mem_read  = id_mem_read;

        unique case (srca_sel_e'(id_srcA_sel))
            SRCA_RS1:  entry_d.src_a = rs1_val;
            SRCA_IMM:  entry_d.src_a = id_immed;
            SRCA_PC:   entry_d.src_a = id_pc;
            SRCA_ZERO: entry_d.src_a = '0;
        endcase

        unique case (srcb_sel_e'(id_srcB_sel))
            SRCB_RS2:  entry_d.src_b = rs2_val;
            SRCB_IMM:  entry_d.src_b = id_immed;
            SRCB_FOUR: entry_d.src_b = XLEN'(4);
            SRCB_ZERO: entry_d.src_b = '0;
        endcase
    end

    // A load leaving while its consumer waits arms the extra bubble; flush cancels any pending bubble.
    always_comb begin
        bubble_d = bubble_q;
        if (flush)
            bubble_d = 2'd0;
        else if (depart && lu_hazard)
            bubble_d = 2'(LU_BUBBLE);
        else if (bubble_q != 2'd0)
            bubble_d = bubble_q - 2'd1;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q  <= 1'b0;
            entry_q  <= '0;
            bubble_q <= 2'd0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (capture)
                valid_q <= 1'b1;
            else if (ex_ready)
                valid_q <= 1'b0;

            if (capture)
                entry_q <= entry_d;

            bubble_q <= bubble_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_srcA      = entry_q.src_a;
    assign ex_srcB      = entry_q.src_b;
    assign ex_alu_fun   = entry_q.alu_fun;
    assign ex_rs2_data  = entry_q.rs2_data;
    assign ex_rd_addr   = entry_q.rd_addr;
    assign ex_reg_write = entry_q.reg_write;
    assign ex_mem_read  = entry_q.mem_read;

endmodule

// File: tb/tb_otter_ex_operand_stage.sv
// Directed testbench for otter_ex_operand_stage (LU_BUBBLE=1); covers both OTTER_FWD_EN builds.
module tb_otter_ex_operand_stage;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [4:0]      id_rs1_addr, id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_immed, id_pc;
    logic [1:0]      id_srcA_sel, id_srcB_sel;
    logic [3:0]      id_alu_fun;
    logic [4:0]      id_rd_addr;
    logic            id_reg_write, id_mem_read;
    logic [4:0]      fwd1_rd, fwd0_rd;
    logic            fwd1_we, fwd0_we;
    logic [XLEN-1:0] fwd1_data, fwd0_data;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_srcA, ex_srcB, ex_rs2_data;
    logic [3:0]      ex_alu_fun;
    logic [4:0]      ex_rd_addr;
    logic            ex_reg_write, ex_mem_read;

    int n_checks = 0;
    int n_errors = 0;

    otter_ex_operand_stage #(.XLEN(XLEN), .LU_BUBBLE(1)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_immed(id_immed), .id_pc(id_pc),
        .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel),
        .id_alu_fun(id_alu_fun), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd1_rd(fwd1_rd), .fwd1_we(fwd1_we), .fwd1_data(fwd1_data),
        .fwd0_rd(fwd0_rd), .fwd0_we(fwd0_we), .fwd0_data(fwd0_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_alu_fun(ex_alu_fun),
        .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_immed = '0; id_pc = '0; id_srcA_sel = '0; id_srcB_sel = '0;
        id_alu_fun = '0; id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        fwd1_rd = '0; fwd1_we = 1'b0; fwd1_data = '0;
        fwd0_rd = '0; fwd0_we = 1'b0; fwd0_data = '0;
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                         input logic [1:0] asel, input logic [1:0] bsel, input logic [3:0] fun,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = 1'b1;
        id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_immed = imm; id_pc = pc; id_srcA_sel = asel; id_srcB_sel = bsel;
        id_alu_fun = fun; id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_srcA", ex_srcA, 32'd0);
        check("rst_srcB", ex_srcB, 32'd0);
        check("rst_fun", 32'(ex_alu_fun), 32'd0);
        check("rst_ready", 32'(id_ready), 32'd1);

        // ADD x3,x1,x2
        drive(5'd1, 5'd2, 32'd5, 32'd7, '0, '0, 2'd0, 2'd0, 4'h0, 5'd3, 1'b1, 1'b0);
        #1 check("add_ready", 32'(id_ready), 32'd1);
        tick();
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_srcA", ex_srcA, 32'd5);
        check("add_srcB", ex_srcB, 32'd7);
        check("add_rs2", ex_rs2_data, 32'd7);
        check("add_rd", 32'(ex_rd_addr), 32'd3);
        check("add_rw", 32'(ex_reg_write), 32'd1);

        // Mux codes: pc / const 4, then imm / zero with store data, then zero / negative imm
        drive('0, '0, '0, '0, '0, 32'h100, 2'd2, 2'd2, 4'hA, '0, 1'b0, 1'b0);
        tick();
        check("pc_srcA", ex_srcA, 32'h100);
        check("four_srcB", ex_srcB, 32'd4);
        check("fun_pass", 32'(ex_alu_fun), 32'hA);
        drive('0, 5'd6, '0, 32'hDEAD, 32'h1234_5000, '0, 2'd1, 2'd3, 4'h3, '0, 1'b0, 1'b0);
        tick();
        check("imm_srcA", ex_srcA, 32'h1234_5000);
        check("zero_srcB", ex_srcB, 32'd0);
        check("store_data", ex_rs2_data, 32'hDEAD);
        drive('0, '0, '0, '0, 32'hFFFF_FFF8, '0, 2'd3, 2'd1, 4'h8, '0, 1'b0, 1'b0);
        tick();
        check("zero_srcA", ex_srcA, 32'd0);
        check("imm_srcB", ex_srcB, 32'hFFFF_FFF8);

        // Consume without capture
        idle();
        tick();
        check("consume_valid", 32'(ex_valid), 32'd0);

        // fwd1 and fwd0 both target x1
        drive(5'd1, '0, 32'h11, '0, '0, '0, 2'd0, 2'd3, 4'h0, '0, 1'b0, 1'b0);
        fwd1_rd = 5'd1; fwd1_we = 1'b1; fwd1_data = 32'hAA;
        fwd0_rd = 5'd1; fwd0_we = 1'b1; fwd0_data = 32'hBB;
`ifdef OTTER_FWD_EN
        #1 check("fwd_ready", 32'(id_ready), 32'd1);
        tick();
        check("fwd1_prio", ex_srcA, 32'hAA);
        fwd1_we = 1'b0;
        tick();
        check("fwd0_sel", ex_srcA, 32'hBB);
`else
        #1 check("raw_fwd1_stall", 32'(id_ready), 32'd0);
        tick();
        check("raw_no_capture", 32'(ex_valid), 32'd0);
        fwd1_we = 1'b0;
        #1 check("raw_fwd0_stall", 32'(id_ready), 32'd0);
        tick();
        fwd0_we = 1'b0;
        #1 check("raw_release", 32'(id_ready), 32'd1);
        tick();
        check("raw_srcA", ex_srcA, 32'h11);
`endif
        // x0 reads zero and is never forwarded
        drive('0, '0, 32'h11, '0, '0, '0, 2'd0, 2'd3, 4'h0, '0, 1'b0, 1'b0);
        fwd1_rd = 5'd0; fwd1_we = 1'b1; fwd1_data = 32'hAA; fwd0_we = 1'b0;
        #1 check("x0_ready", 32'(id_ready), 32'd1);
        tick();
        check("x0_srcA", ex_srcA, 32'd0);
        fwd1_we = 1'b0;

        // fwd0 targets x2, consumer reads rs2 via srcB
        drive('0, 5'd2, '0, 32'h22, '0, '0, 2'd3, 2'd0, 4'h0, '0, 1'b0, 1'b0);
        fwd0_rd = 5'd2; fwd0_we = 1'b1; fwd0_data = 32'h99;
`ifdef OTTER_FWD_EN
        #1 check("fwd0_rs2_ready", 32'(id_ready), 32'd1);
        tick();
        check("fwd0_rs2", ex_srcB, 32'h99);
`else
        #1 check("fwd0_rs2_stall", 32'(id_ready), 32'd0);
        tick();
        check("fwd0_rs2_stall2", 32'(id_ready), 32'd0);
        fwd0_we = 1'b0;
        #1 check("fwd0_rs2_release", 32'(id_ready), 32'd1);
        tick();
        check("fwd0_rs2_srcB", ex_srcB, 32'h22);
`endif
        fwd0_we = 1'b0;

        // Load-use: LW x4 then ADD x5,x4,x4
        drive('0, '0, '0, '0, 32'h10, '0, 2'd0, 2'd1, 4'h0, 5'd4, 1'b1, 1'b1);
        tick();
        check("lw_valid", 32'(ex_valid), 32'd1);
        check("lw_memrd", 32'(ex_mem_read), 32'd1);
        drive(5'd4, 5'd4, 32'h40, 32'h41, '0, '0, 2'd0, 2'd0, 4'h0, 5'd5, 1'b1, 1'b0);
        #1 check("lu_hazard", 32'(id_ready), 32'd0);
        tick();
        check("lu_depart", 32'(ex_valid), 32'd0);
        check("lu_bubble", 32'(id_ready), 32'd0);
        tick();
        check("lu_release", 32'(id_ready), 32'd1);
        tick();
        check("lu_cap_valid", 32'(ex_valid), 32'd1);
        check("lu_cap_srcA", ex_srcA, 32'h40);
        check("lu_cap_srcB", ex_srcB, 32'h41);
        check("lu_cap_rd", 32'(ex_rd_addr), 32'd5);

        // Load to x0 never stalls; x0 operand reads zero
        drive('0, '0, '0, '0, 32'h20, '0, 2'd0, 2'd1, 4'h0, 5'd0, 1'b1, 1'b1);
        tick();
        drive('0, '0, 32'h33, 32'h33, '0, '0, 2'd0, 2'd0, 4'h0, 5'd9, 1'b0, 1'b0);
        #1 check("lu_x0_ready", 32'(id_ready), 32'd1);
        tick();
        check("lu_x0_srcA", ex_srcA, 32'd0);

        // rs2-only load-use, killed by flush as the load departs: no bubble left behind
        drive('0, '0, '0, '0, 32'h30, '0, 2'd0, 2'd1, 4'h0, 5'd8, 1'b1, 1'b1);
        tick();
        drive('0, 5'd8, '0, 32'h88, 32'h1, '0, 2'd1, 2'd0, 4'h0, 5'd10, 1'b0, 1'b0);
        #1 check("lu_rs2_hazard", 32'(id_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_no_bubble", 32'(id_ready), 32'd1);

        // RST during a load-use stall leaves no pending bubble
        drive('0, '0, '0, '0, 32'h40, '0, 2'd0, 2'd1, 4'h0, 5'd4, 1'b1, 1'b1);
        tick();
        drive(5'd4, 5'd4, 32'h40, 32'h41, '0, '0, 2'd0, 2'd0, 4'h0, 5'd5, 1'b1, 1'b0);
        #1 check("rst_stall_hz", 32'(id_ready), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("rst_stall_valid", 32'(ex_valid), 32'd0);
        check("rst_stall_ready", 32'(id_ready), 32'd1);

        // Back-pressure: held entry frozen for 3 cycles, then flushed
        drive('0, '0, '0, '0, 32'h55, '0, 2'd1, 2'd3, 4'h2, 5'd7, 1'b1, 1'b0);
        tick();
        check("hold_cap", ex_srcA, 32'h55);
        ex_ready = 1'b0;
        drive('0, '0, '0, '0, 32'h66, '0, 2'd1, 2'd3, 4'h3, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("hold_ready%0d", i), 32'(id_ready), 32'd0);
            tick();
            check($sformatf("hold_srcA%0d", i), ex_srcA, 32'h55);
            check($sformatf("hold_fun%0d", i), 32'(ex_alu_fun), 32'h2);
            check($sformatf("hold_valid%0d", i), 32'(ex_valid), 32'd1);
        end
        flush = 1'b1;
        tick();
        check("hold_flush", 32'(ex_valid), 32'd0);

        // Flush beats a simultaneous capture
        ex_ready = 1'b1;
        #1 check("flush_cap_ready", 32'(id_ready), 32'd1);
        tick();
        check("flush_cap_valid", 32'(ex_valid), 32'd0);
        check("flush_cap_srcA", ex_srcA, 32'h55);
        flush = 1'b0;
        tick();
        check("cap_after_flush", ex_srcA, 32'h66);
        check("cap_after_valid", 32'(ex_valid), 32'd1);

        // Consume and capture together: back-to-back, no bubble
        drive('0, '0, '0, '0, 32'h77, '0, 2'd1, 2'd3, 4'h1, 5'd0, 1'b0, 1'b0);
        #1 check("b2b_ready", 32'(id_ready), 32'd1);
        tick();
        check("b2b_srcA", ex_srcA, 32'h77);
        check("b2b_valid", 32'(ex_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
